// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the multicycle controller and
// the memory responder.
//   req_rd, req_wr : level requests from the controller
//   addr, wdata    : access address and write data, sampled with the request
//   rdata          : read data, valid while ready=1
//   ready          : one-cycle completion pulse
//   err            : error qualifier, valid only while ready=1
//   busy           : responder is in an access (WAIT/RESP)
// master = controller side, slave = responder side.
interface mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req_rd, req_wr, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req_rd, req_wr, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data RAM behind the multicycle controller.
// Inserts WAIT_CYCLES wait states per access and returns a one-cycle ready
// pulse with read data or an error flag. A side-band loader writes the RAM
// while the responder is idle and no request is present.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : mem_responder_if.slave (req_rd/req_wr/addr/wdata in,
//              rdata/ready/err/busy out)
//   ld_en    : loader write strobe
//   ld_addr  : loader address
//   ld_data  : loader data
//
// state  | meaning
// S_IDLE | waiting for a request; loader writes accepted here
// S_WAIT | counting down wait states; bus inputs ignored
// S_RESP | ready pulse cycle; returns to S_IDLE unconditionally
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [3:0]      WAIT_L  = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              start;
  logic              enter_resp;
  logic              acc_rd;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              oob;
  logic              conflict;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // With zero wait states RESP is entered straight from IDLE, so the access
  // fields come from the bus in IDLE and from the latched copy otherwise.
  always_comb begin
    start      = (state == S_IDLE) && (bus.req_rd || bus.req_wr);
    acc_rd     = (state == S_IDLE) ? bus.req_rd : rd_q;
    acc_wr     = (state == S_IDLE) ? bus.req_wr : wr_q;
    acc_addr   = (state == S_IDLE) ? bus.addr   : addr_q;
    acc_wdata  = (state == S_IDLE) ? bus.wdata  : wdata_q;
    enter_resp = (start && (WAIT_L == 4'd0)) || ((state == S_WAIT) && (cnt == 4'd1));
    oob        = ({1'b0, acc_addr} >= DEPTH_L);
    conflict   = acc_rd && acc_wr;

    mem_we = 1'b0;
    mem_wa = ld_addr;
    mem_wd = ld_data;
    if (enter_resp && acc_wr && !acc_rd && !oob) begin
      mem_we = 1'b1;
      mem_wa = acc_addr;
      mem_wd = acc_wdata;
    end else if ((state == S_IDLE) && !start && ld_en && ({1'b0, ld_addr} < DEPTH_L)) begin
      mem_we = 1'b1;
    end
  end

  // RAM is not reset; a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_q     <= bus.req_rd;
            wr_q     <= bus.req_wr;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            cnt      <= WAIT_L;
            bus.busy <= 1'b1;
            state    <= (WAIT_L == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase

      if (enter_resp) begin
        bus.ready <= 1'b1;
        bus.err   <= oob || conflict;
        if (oob) begin
          bus.rdata <= '0;
        end else if (acc_rd && !acc_wr) begin
          bus.rdata <= mem[acc_addr];
        end
      end
    end
  end

endmodule
